// File: rtl/digit_scanner_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment scanner.
package digit_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam int DIV_DEFAULT       = 50000;
  localparam int BLANK_CYC_DEFAULT = 500;
  localparam int NUM_DIGITS        = 4;

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] k);
    return v[k*4 +: 4];
  endfunction

endpackage

// File: rtl/digit_scanner_scan_timer.sv
// Slot cycle counter and digit index counter, with look-ahead strobes so the
// top can register its outputs one cycle before each boundary.
module scan_timer
  import digit_scanner_pkg::*;
#(
  parameter int DIV       = DIV_DEFAULT,
  parameter int BLANK_CYC = BLANK_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] idx_o,
  output logic       pre_show_o,
  output logic       slot_last_o,
  output logic       pre_frame_o,
  output logic       frame_last_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(DIV - 2);
  localparam logic [CNT_W-1:0] CNT_PRE_SHOW = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             slot_last;

  assign slot_last = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign pre_show_o   = (cnt_q == CNT_PRE_SHOW);
  assign slot_last_o  = slot_last;
  assign pre_frame_o  = (cnt_q == CNT_PRE_LAST) && (idx_q == 2'd3);
  assign frame_last_o = slot_last && (idx_q == 2'd3);

endmodule

// File: rtl/digit_scanner.sv
// Four-digit multiplexed display driver: per-slot BLANK/SHOW FSM, frame-aligned
// double buffering of the displayed value and leading-zero suppression.
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int DIV       = DIV_DEFAULT,
  parameter int BLANK_CYC = BLANK_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic [3:0]  digit_n,
  output logic        loaded,
  output logic        frame_done
);

  generate
    if (DIV < 4 || BLANK_CYC < 1 || BLANK_CYC >= DIV - 1) begin : g_bad_params
      $error("digit_scanner: need DIV >= 4 and 1 <= BLANK_CYC <= DIV-2");
    end
  endgenerate

  logic [1:0] idx;
  logic       pre_show, slot_last, pre_frame, frame_last;

  scan_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .idx_o        (idx),
    .pre_show_o   (pre_show),
    .slot_last_o  (slot_last),
    .pre_frame_o  (pre_frame),
    .frame_last_o (frame_last)
  );

  logic [15:0] stage_q, stage_d;
  logic [15:0] disp_q, disp_d;
  logic        pending_q, pending_d;

  // A load on the boundary cycle still lets the old staged value through,
  // and keeps pending set for the new one.
  always_comb begin
    stage_d   = stage_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (frame_last && pending_q) begin
      disp_d    = stage_q;
      pending_d = 1'b0;
    end
    if (load) begin
      stage_d   = value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q   <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
    end
  end

  function automatic logic suppressed(input logic [15:0] v, input logic [1:0] k,
                                      input logic en);
    case (k)
      2'd1:    return en && (v[15:4] == 12'h000);
      2'd2:    return en && (v[15:8] == 8'h00);
      2'd3:    return en && (v[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

  scan_state_e state_q;
  logic [3:0]  digit_n_q;
  logic [3:0]  nib_q;
  logic        loaded_q, frame_done_q;
  logic [1:0]  idx_nx;

  assign idx_nx = idx + 2'd1;

  // Outputs are loaded one cycle ahead of each boundary so they change
  // exactly on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      digit_n_q    <= 4'b1111;
      nib_q        <= 4'h0;
      loaded_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      loaded_q     <= pre_frame && (pending_q || load);
      frame_done_q <= pre_frame;
      case (state_q)
        ST_BLANK: begin
          if (pre_show) begin
            state_q   <= ST_SHOW;
            digit_n_q <= suppressed(disp_q, idx, lz_en) ? 4'b1111 : ~(4'b0001 << idx);
          end
        end
        ST_SHOW: begin
          if (slot_last) begin
            state_q   <= ST_BLANK;
            digit_n_q <= 4'b1111;
            nib_q     <= nibble_sel(disp_d, idx_nx);
          end
        end
        default: state_q <= ST_BLANK;
      endcase
    end
  end

  assign {A, B, C, D} = nib_q;
  assign digit_n      = digit_n_q;
  assign loaded       = loaded_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner at DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_digit_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        lz_en = 1'b0;
  logic        A, B, C, D;
  logic [3:0]  digit_n;
  logic        loaded, frame_done;

  digit_scanner #(.DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .digit_n    (digit_n),
    .loaded     (loaded),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rs;
    int          cyc;
    bit          ld;
    logic [15:0] val;
    bit          lz;
    logic [3:0]  dn;
    logic [3:0]  nib;
    bit          lo;
    bit          fd;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic vec_t mk(bit rs, int c, bit ld, logic [15:0] v, bit lz,
                              logic [3:0] dn, logic [3:0] nib, bit lo, bit fd);
    vec_t t;
    t.rs = rs; t.cyc = c; t.ld = ld; t.val = v; t.lz = lz;
    t.dn = dn; t.nib = nib; t.lo = lo; t.fd = fd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] dn, input logic [3:0] nib,
                          input bit lo, input bit fd);
    chk({tag, " digit_n"}, {12'h0, digit_n}, {12'h0, dn});
    chk({tag, " ABCD"}, {12'h0, A, B, C, D}, {12'h0, nib});
    chk({tag, " loaded"}, {15'h0, loaded}, {15'h0, lo});
    chk({tag, " frame_done"}, {15'h0, frame_done}, {15'h0, fd});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    load  = 1'b0;
    lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("in reset", 4'hF, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic advance(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    // Scenario 1: reset and scan timing with display = 0
    tbl.push_back(mk(1, 0,  0, 16'h0, 0, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 1,  0, 16'h0, 0, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 2,  0, 16'h0, 0, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 7,  0, 16'h0, 0, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 8,  0, 16'h0, 0, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 10, 0, 16'h0, 0, 4'hD, 4'h0, 0, 0));
    tbl.push_back(mk(0, 18, 0, 16'h0, 0, 4'hB, 4'h0, 0, 0));
    tbl.push_back(mk(0, 26, 0, 16'h0, 0, 4'h7, 4'h0, 0, 0));
    tbl.push_back(mk(0, 30, 0, 16'h0, 0, 4'h7, 4'h0, 0, 0));
    tbl.push_back(mk(0, 31, 0, 16'h0, 0, 4'h7, 4'h0, 0, 1));
    tbl.push_back(mk(0, 32, 0, 16'h0, 0, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 34, 0, 16'h0, 0, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 63, 0, 16'h0, 0, 4'h7, 4'h0, 0, 1));
    // Scenario 2: single load 0x1234
    tbl.push_back(mk(1, 5,  1, 16'h1234, 0, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 30, 0, 16'h0, 0, 4'h7, 4'h0, 0, 0));
    tbl.push_back(mk(0, 31, 0, 16'h0, 0, 4'h7, 4'h0, 1, 1));
    tbl.push_back(mk(0, 32, 0, 16'h0, 0, 4'hF, 4'h4, 0, 0));
    tbl.push_back(mk(0, 34, 0, 16'h0, 0, 4'hE, 4'h4, 0, 0));
    tbl.push_back(mk(0, 40, 0, 16'h0, 0, 4'hF, 4'h3, 0, 0));
    tbl.push_back(mk(0, 42, 0, 16'h0, 0, 4'hD, 4'h3, 0, 0));
    tbl.push_back(mk(0, 50, 0, 16'h0, 0, 4'hB, 4'h2, 0, 0));
    tbl.push_back(mk(0, 58, 0, 16'h0, 0, 4'h7, 4'h1, 0, 0));
    tbl.push_back(mk(0, 63, 0, 16'h0, 0, 4'h7, 4'h1, 0, 1));
    tbl.push_back(mk(0, 64, 0, 16'h0, 0, 4'hF, 4'h4, 0, 0));
    // Scenario 3: overwrite before the boundary
    tbl.push_back(mk(1, 3,  1, 16'hAAAA, 0, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 10, 1, 16'h5555, 0, 4'hD, 4'h0, 0, 0));
    tbl.push_back(mk(0, 31, 0, 16'h0, 0, 4'h7, 4'h0, 1, 1));
    tbl.push_back(mk(0, 32, 0, 16'h0, 0, 4'hF, 4'h5, 0, 0));
    tbl.push_back(mk(0, 42, 0, 16'h0, 0, 4'hD, 4'h5, 0, 0));
    tbl.push_back(mk(0, 50, 0, 16'h0, 0, 4'hB, 4'h5, 0, 0));
    tbl.push_back(mk(0, 58, 0, 16'h0, 0, 4'h7, 4'h5, 0, 0));
    tbl.push_back(mk(0, 63, 0, 16'h0, 0, 4'h7, 4'h5, 0, 1));
    // Scenario 4: load on the boundary cycle
    tbl.push_back(mk(1, 20, 1, 16'h1111, 0, 4'hB, 4'h0, 0, 0));
    tbl.push_back(mk(0, 31, 1, 16'h2222, 0, 4'h7, 4'h0, 1, 1));
    tbl.push_back(mk(0, 32, 0, 16'h0, 0, 4'hF, 4'h1, 0, 0));
    tbl.push_back(mk(0, 58, 0, 16'h0, 0, 4'h7, 4'h1, 0, 0));
    tbl.push_back(mk(0, 63, 0, 16'h0, 0, 4'h7, 4'h1, 1, 1));
    tbl.push_back(mk(0, 64, 0, 16'h0, 0, 4'hF, 4'h2, 0, 0));
    tbl.push_back(mk(0, 90, 0, 16'h0, 0, 4'h7, 4'h2, 0, 0));
    tbl.push_back(mk(0, 95, 0, 16'h0, 0, 4'h7, 4'h2, 0, 1));
    // Scenario 5: leading-zero suppression
    tbl.push_back(mk(1, 0,  1, 16'h0040, 1, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 31, 0, 16'h0, 1, 4'hF, 4'h0, 1, 1));
    tbl.push_back(mk(0, 34, 0, 16'h0, 1, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 40, 1, 16'h0000, 1, 4'hF, 4'h4, 0, 0));
    tbl.push_back(mk(0, 42, 0, 16'h0, 1, 4'hD, 4'h4, 0, 0));
    tbl.push_back(mk(0, 48, 0, 16'h0, 1, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 50, 0, 16'h0, 1, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 58, 0, 16'h0, 1, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 63, 0, 16'h0, 1, 4'hF, 4'h0, 1, 1));
    tbl.push_back(mk(0, 66, 0, 16'h0, 1, 4'hE, 4'h0, 0, 0));
    tbl.push_back(mk(0, 74, 0, 16'h0, 1, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 82, 0, 16'h0, 1, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 90, 0, 16'h0, 1, 4'hF, 4'h0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      advance(tbl[i].cyc);
      load  = tbl[i].ld;
      value = tbl[i].val;
      lz_en = tbl[i].lz;
      chk_outs($sformatf("vec%0d c%0d", i, tbl[i].cyc), tbl[i].dn, tbl[i].nib,
               tbl[i].lo, tbl[i].fd);
    end

    // Scenario 6: reset while a value is pending discards it
    begin
      int n_loaded;
      int n_fd;
      int n_nib;
      int fd_at[$];
      do_reset();
      advance(4);
      load  = 1'b1;
      value = 16'hBEEF;
      advance(12);
      chk_outs("s6 pre-reset", 4'hD, 4'h0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      chk_outs("s6 reset mid-show", 4'hF, 4'h0, 1'b0, 1'b0);
      step();
      chk_outs("s6 reset hold", 4'hF, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc = 0;
      n_loaded = 0; n_fd = 0; n_nib = 0;
      for (int k = 0; k < 64; k++) begin
        if (loaded) n_loaded++;
        if (frame_done) begin
          n_fd++;
          fd_at.push_back(cyc);
        end
        if ({A, B, C, D} != 4'h0) n_nib++;
        if (cyc == 2) chk("s6 c2 digit_n", {12'h0, digit_n}, 16'h000E);
        step();
      end
      chk("s6 loaded pulses", n_loaded[15:0], 16'd0);
      chk("s6 nonzero nibbles", n_nib[15:0], 16'd0);
      chk("s6 frame_done count", n_fd[15:0], 16'd2);
      if (fd_at.size() == 2) begin
        chk("s6 frame_done first", fd_at[0][15:0], 16'd31);
        chk("s6 frame_done second", fd_at[1][15:0], 16'd63);
      end else begin
        n_cmp++;
        n_bad++;
        $display("FAIL s6 frame_done positions: got %0d pulses expected 2", fd_at.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
